mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one unified memory port between an instruction-fetch master and a
// data (load/store) master. Only one access is in flight at a time. Data
// normally wins arbitration. A starvation counter lets a waiting fetch through
// after STARVE_LIMIT back-to-back data grants.
//
// Handshakes:
//   Each master holds *_req (and its address/data) until its one-cycle
//   *_valid pulse. The memory side holds mem_req and all mem_* fields stable
//   until mem_ready is sampled high. A read's data is returned on the single
//   mem_rvalid cycle that follows acceptance. mem_rvalid is only honoured while
//   the arbiter waits for that read.
//
// Ports:
//   clk, reset            core clock; asynchronous active-high reset
//   i_req/i_addr/i_flush  fetch request, address and fetch cancel
//   i_rdata/i_valid       fetched word and its one-cycle valid pulse
//   d_req/d_we/d_addr/d_wdata/d_be
//                         data request: store when d_we=1, load otherwise
//   d_rdata/d_valid       load data / store-complete pulse
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be
//                         unified memory request (mem_be is 4'hF on reads)
//   mem_ready             memory accepts the request this cycle
//   mem_rvalid/mem_rdata  read data return
//   dbgState              current FSM state (IDLE=0, ISSUE=1, RESP=2)
//   dbgOwner              owner of the current access (0=INSTR, 1=DATA)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_flush,
    output logic [31:0] i_rdata,
    output logic        i_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbgState,
    output logic        dbgOwner
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } stateT;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } ownerT;

    stateT            state;
    stateT            stateNext;
    ownerT            owner;
    logic [CNT_W-1:0] starveCnt;
    logic             flushed;

    logic iEligible;
    logic dEligible;
    logic respPulse;
    logic instrWins;
    logic instrOwned;
    logic grantInstr;
    logic grantData;
    logic flushAbort;
    logic storeDone;
    logic readDone;

    // A port whose valid is high this cycle has not yet had the chance to
    // drop or replace its request, so its req is ignored. A flush also blocks
    // a fetch grant in the same cycle.
    assign iEligible  = i_req & ~i_valid & ~i_flush;
    assign dEligible  = d_req & ~d_valid;

    // No grant at all is made in a response cycle. Otherwise the other port
    // would slip in every time a data access completes and the starvation
    // counter could never build up against a continuous data stream.
    assign respPulse  = i_valid | d_valid;

    assign instrWins  = iEligible && (starveCnt == LIMIT);
    assign instrOwned = (owner == OWN_INSTR);

    // Fetch cancelled before the memory took it: abandon without a response.
    assign flushAbort = (state == ISSUE) && instrOwned && i_flush && !mem_ready;

    // Only the data port ever writes, so a store completion is always DATA.
    assign storeDone  = (state == ISSUE) && mem_ready && mem_we;
    assign readDone   = (state == RESP) && mem_rvalid;

    assign mem_req    = (state == ISSUE);
    assign dbgState   = state;
    assign dbgOwner   = owner;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and grant decision
    always_comb begin
        stateNext  = state;
        grantInstr = 1'b0;
        grantData  = 1'b0;
        case (state)
            IDLE: begin
                if (!respPulse) begin
                    if (instrWins) begin
                        grantInstr = 1'b1;
                    end else if (dEligible) begin
                        grantData = 1'b1;
                    end else if (iEligible) begin
                        grantInstr = 1'b1;
                    end
                end
                if (grantInstr || grantData) begin
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                if (flushAbort) begin
                    stateNext = IDLE;
                end else if (mem_ready) begin
                    stateNext = mem_we ? IDLE : RESP;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Request registers, starvation counter and response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner     <= OWN_INSTR;
            starveCnt <= '0;
            flushed   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            i_rdata   <= '0;
            i_valid   <= 1'b0;
            d_rdata   <= '0;
            d_valid   <= 1'b0;
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;

            if (grantData) begin
                owner     <= OWN_DATA;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_be    <= d_we ? d_be : 4'hF;
            end else if (grantInstr) begin
                owner     <= OWN_INSTR;
                mem_we    <= 1'b0;
                mem_addr  <= i_addr;
                mem_wdata <= '0;
                mem_be    <= 4'hF;
            end

            if (grantData || grantInstr) begin
                flushed <= 1'b0;
                // Counts data grants that made a raw i_req wait.
                if (grantInstr || !i_req) begin
                    starveCnt <= '0;
                end else if (starveCnt != LIMIT) begin
                    starveCnt <= starveCnt + 1'b1;
                end
            end else if (instrOwned && i_flush &&
                         (((state == ISSUE) && mem_ready) || (state == RESP))) begin
                // Too late to cancel on the bus: let the read finish, drop the result.
                flushed <= 1'b1;
            end

            if (storeDone) begin
                d_valid <= 1'b1;
            end

            if (readDone) begin
                if (!instrOwned) begin
                    d_rdata <= mem_rdata;
                    d_valid <= 1'b1;
                end else if (!flushed && !i_flush) begin
                    i_rdata <= mem_rdata;
                    i_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed scenarios for latency, priority, flush and reset behaviour,
// followed by randomized traffic in which the bench plays both masters and
// the memory. Expected grant order and read data come from a transaction-level
// model: pending-request queues, a starvation count and a golden memory array.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int STARVE_LIMIT = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        i_req;
    logic [31:0] i_addr;
    logic        i_flush;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [1:0]  dbgState;
    logic        dbgOwner;

    mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_flush   (i_flush),
        .i_rdata   (i_rdata),
        .i_valid   (i_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ready (mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .dbgState  (dbgState),
        .dbgOwner  (dbgOwner)
    );

    // ---------------- scoreboard state ----------------
    int nAsserts = 0;
    int nFails   = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dAccT;

    logic [31:0] iAddrQ[$];
    dAccT        dQ[$];
    logic [31:0] expIQ[$];
    logic [31:0] expDQ[$];
    logic [31:0] goldMem[logic [31:0]];
    logic [31:0] respMem[logic [31:0]];
    int          modelCnt = 0;
    string       grantLog;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] seedWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] goldRead(input logic [31:0] a);
        return goldMem.exists(a) ? goldMem[a] : seedWord(a);
    endfunction

    function automatic logic [31:0] respRead(input logic [31:0] a);
        return respMem.exists(a) ? respMem[a] : seedWord(a);
    endfunction

    // ---------------- driver: both masters plus a randomized memory ----------------
    task automatic runTraffic(input int maxCycles);
        bit          busy = 0;
        bit          readPending = 0;
        bit          acceptDrv = 0;
        bit          rvalidDrv = 0;
        bit          curInstr = 0;
        bit          curWe = 0;
        logic [31:0] curAddr = '0;
        logic [31:0] curWdata = '0;
        logic [3:0]  curBe = '0;
        int          rvDelay = 0;
        int          cycles = 0;
        bit          expI;
        bit          expD;
        bit          iPend;
        bit          dPend;
        bit          pickInstr;
        dAccT        dh;
        while ((iAddrQ.size() > 0 || dQ.size() > 0 || busy) && cycles < maxCycles) begin
            // drive phase
            i_req  = (iAddrQ.size() > 0);
            i_addr = (iAddrQ.size() > 0) ? iAddrQ[0] : 32'h0;
            if (dQ.size() > 0) begin
                dh      = dQ[0];
                d_req   = 1'b1;
                d_we    = dh.we;
                d_addr  = dh.addr;
                d_wdata = dh.wdata;
                d_be    = dh.be;
            end else begin
                d_req = 1'b0;
            end
            mem_ready = mem_req ? ($urandom_range(0, 2) != 0) : 1'($urandom_range(0, 1));
            acceptDrv = mem_req && mem_ready;
            if (readPending) begin
                if (rvDelay == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = respRead(curAddr);
                    rvalidDrv  = 1'b1;
                end else begin
                    rvDelay--;
                    mem_rvalid = 1'b0;
                    rvalidDrv  = 1'b0;
                end
            end else begin
                // stray return data while nothing is outstanding
                mem_rvalid = ($urandom_range(0, 3) == 0);
                mem_rdata  = $urandom;
                rvalidDrv  = 1'b0;
            end

            tick();

            // evaluate phase
            expI = rvalidDrv && curInstr;
            expD = (rvalidDrv && !curInstr) || (acceptDrv && curWe);
            if (acceptDrv) begin
                if (curWe) begin
                    respMem[curAddr] = mergeBytes(respRead(curAddr), curWdata, curBe);
                    busy = 1'b0;
                end else begin
                    readPending = 1'b1;
                    rvDelay     = $urandom_range(0, 2);
                end
            end
            if (rvalidDrv) begin
                busy        = 1'b0;
                readPending = 1'b0;
            end
            check("i_valid_pulse", i_valid, expI);
            check("d_valid_pulse", d_valid, expD);
            if (expI && expIQ.size() > 0) begin
                check("i_rdata", i_rdata, expIQ.pop_front());
                void'(iAddrQ.pop_front());
            end
            if (expD && dQ.size() > 0) begin
                if (!curWe && expDQ.size() > 0) check("d_rdata", d_rdata, expDQ.pop_front());
                void'(dQ.pop_front());
            end

            if (mem_req && !busy) begin
                iPend     = (iAddrQ.size() > 0);
                dPend     = (dQ.size() > 0);
                pickInstr = iPend && (!dPend || modelCnt == STARVE_LIMIT);
                if (pickInstr || !iPend) modelCnt = 0;
                else if (modelCnt < STARVE_LIMIT) modelCnt++;
                grantLog = {grantLog, mem_addr[15] ? "D" : "I"};
                busy      = 1'b1;
                curInstr  = pickInstr;
                curAddr   = mem_addr;
                curWe     = mem_we;
                curWdata  = mem_wdata;
                curBe     = mem_be;
                if (pickInstr) begin
                    check("grant_i_addr", mem_addr, iAddrQ[0]);
                    check("grant_i_we", mem_we, 1'b0);
                    check("grant_i_be", mem_be, 4'hF);
                    expIQ.push_back(goldRead(iAddrQ[0]));
                end else if (dPend) begin
                    dh = dQ[0];
                    check("grant_d_addr", mem_addr, dh.addr);
                    check("grant_d_we", mem_we, dh.we);
                    check("grant_d_be", mem_be, dh.we ? dh.be : 4'hF);
                    if (dh.we) begin
                        check("grant_d_wdata", mem_wdata, dh.wdata);
                        goldMem[dh.addr] = mergeBytes(goldRead(dh.addr), dh.wdata, dh.be);
                    end else begin
                        expDQ.push_back(goldRead(dh.addr));
                    end
                end
            end
            cycles++;
        end
        check("traffic_drained", (iAddrQ.size() + dQ.size()) + int'(busy), 32'd0);
        i_req      = 1'b0;
        d_req      = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic loadRandom(input int nI, input int nD);
        dAccT a;
        for (int k = 0; k < nI; k++) iAddrQ.push_back(32'h1000 + 4 * $urandom_range(0, 15));
        for (int k = 0; k < nD; k++) begin
            a.we    = 1'($urandom_range(0, 1));
            a.addr  = 32'h8000 + 4 * $urandom_range(0, 7);
            a.wdata = $urandom;
            a.be    = 4'($urandom_range(1, 15));
            dQ.push_back(a);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        dAccT a;
        reset      = 1'b1;
        i_req      = 1'b0;
        i_addr     = '0;
        i_flush    = 1'b0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        d_be       = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (3) tick();

        // reset state
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_be", mem_be, 4'h0);
        check("rst_i_valid", i_valid, 1'b0);
        check("rst_d_valid", d_valid, 1'b0);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_state", dbgState, 2'd0);
        reset = 1'b0;
        tick();

        // single fetch at minimum latency
        i_req = 1'b1; i_addr = 32'h100; mem_ready = 1'b1;
        tick();
        check("f_mem_req", mem_req, 1'b1);
        check("f_mem_addr", mem_addr, 32'h100);
        check("f_mem_be", mem_be, 4'hF);
        check("f_mem_we", mem_we, 1'b0);
        tick();
        check("f_resp_req_low", mem_req, 1'b0);
        check("f_no_early_valid", i_valid, 1'b0);
        mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
        tick();
        check("f_i_valid", i_valid, 1'b1);
        check("f_i_rdata", i_rdata, 32'h0050_0093);
        i_req = 1'b0; mem_rvalid = 1'b0; mem_ready = 1'b0;
        tick();
        check("f_valid_one_cycle", i_valid, 1'b0);
        check("f_rdata_hold", i_rdata, 32'h0050_0093);

        // simultaneous store and fetch: store first
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'h3;
        mem_ready = 1'b1;
        tick();
        check("s_mem_addr", mem_addr, 32'h2000);
        check("s_mem_we", mem_we, 1'b1);
        check("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("s_mem_be", mem_be, 4'h3);
        tick();
        check("s_d_valid", d_valid, 1'b1);
        check("s_i_valid", i_valid, 1'b0);
        d_req = 1'b0;
        tick();
        check("s_no_reissue", mem_req, 1'b0);
        tick();
        check("s_fetch_req", mem_req, 1'b1);
        check("s_fetch_addr", mem_addr, 32'h200);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
        tick();
        check("s_fetch_valid", i_valid, 1'b1);
        check("s_fetch_rdata", i_rdata, 32'h0000_0013);
        check("s_d_rdata_hold", d_rdata, 32'h0);
        i_req = 1'b0; mem_rvalid = 1'b0; mem_ready = 1'b0;
        tick();

        // fetch stalled, then flushed before acceptance
        i_req = 1'b1; i_addr = 32'h300; mem_ready = 1'b0;
        tick();
        for (int c = 1; c <= 3; c++) begin
            check("st_i_req", mem_req, 1'b1);
            check("st_i_addr", mem_addr, 32'h300);
            if (c < 3) tick();
        end
        i_flush = 1'b1; i_req = 1'b0;
        tick();
        check("fl_req_dropped", mem_req, 1'b0);
        i_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        tick();
        check("fl_no_i_valid", i_valid, 1'b0);
        check("fl_i_rdata_hold", i_rdata, 32'h0000_0013);
        check("fl_stray_idle", mem_req, 1'b0);
        mem_rvalid = 1'b0;

        // data load stalled 5 cycles; flush must not disturb it
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8040;
        tick();
        for (int c = 1; c <= 5; c++) begin
            check("st_d_req", mem_req, 1'b1);
            check("st_d_addr", mem_addr, 32'h8040);
            check("st_d_be", mem_be, 4'hF);
            i_flush = (c == 3);
            tick();
        end
        i_flush = 1'b0;
        check("st_d_still_req", mem_req, 1'b1);
        mem_ready = 1'b1;
        tick();
        check("ld_resp_req_low", mem_req, 1'b0);
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
        tick();
        check("ld_d_valid", d_valid, 1'b1);
        check("ld_d_rdata", d_rdata, 32'h1122_3344);
        d_req = 1'b0; mem_rvalid = 1'b0;
        tick();
        check("ld_valid_one_cycle", d_valid, 1'b0);

        // flush while waiting for read data
        i_req = 1'b1; i_addr = 32'h400; mem_ready = 1'b1;
        tick();
        tick();
        i_flush = 1'b1; i_req = 1'b0;
        tick();
        i_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
        tick();
        check("flr_no_i_valid", i_valid, 1'b0);
        check("flr_i_rdata_hold", i_rdata, 32'h0000_0013);
        check("flr_idle", mem_req, 1'b0);
        mem_rvalid = 1'b0;

        // flush in the same cycle the memory accepts
        i_req = 1'b1; i_addr = 32'h410;
        tick();
        i_flush = 1'b1; i_req = 1'b0;
        tick();
        check("fla_resp_req_low", mem_req, 1'b0);
        i_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_CAFE;
        tick();
        check("fla_no_i_valid", i_valid, 1'b0);
        check("fla_i_rdata_hold", i_rdata, 32'h0000_0013);
        mem_rvalid = 1'b0;

        // flush in IDLE blocks the fetch grant for that cycle only
        i_req = 1'b1; i_addr = 32'h420; i_flush = 1'b1;
        tick();
        check("fli_blocked", mem_req, 1'b0);
        i_flush = 1'b0;
        tick();
        check("fli_granted", mem_req, 1'b1);
        check("fli_addr", mem_addr, 32'h420);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_420F;
        tick();
        check("fli_i_valid", i_valid, 1'b1);
        check("fli_i_rdata", i_rdata, 32'h0000_420F);
        i_req = 1'b0; mem_rvalid = 1'b0; mem_ready = 1'b0;
        tick();

        // reset during RESP
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8050; mem_ready = 1'b1;
        tick();
        tick();
        d_req = 1'b0; mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("ar_mem_req", mem_req, 1'b0);
        check("ar_mem_addr", mem_addr, 32'h0);
        check("ar_mem_be", mem_be, 4'h0);
        check("ar_i_rdata", i_rdata, 32'h0);
        check("ar_state", dbgState, 2'd0);
        tick();
        reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        check("ar_no_d_valid", d_valid, 1'b0);
        check("ar_no_i_valid", i_valid, 1'b0);
        check("ar_d_rdata", d_rdata, 32'h0);
        mem_rvalid = 1'b0;
        i_req = 1'b1; i_addr = 32'h500; mem_ready = 1'b1;
        tick();
        check("ar_fetch_addr", mem_addr, 32'h500);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_5555;
        tick();
        check("ar_fetch_valid", i_valid, 1'b1);
        check("ar_fetch_rdata", i_rdata, 32'h0000_5555);
        i_req = 1'b0; mem_rvalid = 1'b0; mem_ready = 1'b0;
        tick();

        // starvation: continuous loads against two fetches
        modelCnt = 0;
        grantLog = "";
        iAddrQ.push_back(32'h1000);
        iAddrQ.push_back(32'h1004);
        for (int k = 0; k < 5; k++) begin
            a.we = 1'b0; a.addr = 32'h8000 + 4 * k; a.wdata = '0; a.be = 4'hF;
            dQ.push_back(a);
        end
        runTraffic(500);
        nAsserts++;
        assert (grantLog == "DDDIDDI") else begin
            nFails++;
            $error("FAIL grant_order: observed %s expected DDDIDDI", grantLog);
        end

        // randomized traffic rounds
        for (int r = 0; r < 4; r++) begin
            loadRandom($urandom_range(3, 12), $urandom_range(3, 16));
            runTraffic(3000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
